// File: rtl/systolic_pkg.sv
// Shared constants, operand/result types and sequencer state encoding for the 4x4 systolic array.
package systolic_pkg;

    localparam int unsigned DIM      = 4;
    localparam int unsigned DW       = 8;
    localparam int unsigned RW       = 16;
    localparam int unsigned FEED_CYC = 2 * DIM - 1;
    localparam int unsigned IDX_W    = $clog2(DIM);
    localparam int unsigned PH_W     = $clog2(FEED_CYC);

    typedef logic signed [DW-1:0] int8_t;
    typedef logic signed [RW-1:0] acc16_t;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StOut
    } state_e;

    // Element k of edge lane `lane` is presented at feed phase t = lane + k.
    function automatic logic skew_hit(input int t, input int lane, input int k);
        return t == lane + k;
    endfunction

endpackage

// File: rtl/systolic_skew_feed.sv
// Operand buffers for A (rows) and B (columns) plus the skew mux driving the array edges.
// Outputs are registered and follow the phase presented one cycle earlier.
module systolic_skew_feed
    import systolic_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_we,
    input  logic                   ld_sel,
    input  logic [IDX_W-1:0]       ld_idx,
    input  logic [DIM*DW-1:0]      ld_data,
    input  logic                   feed_en,
    input  logic [PH_W-1:0]        phase,
    output logic [DIM-1:0][DW-1:0] arr_x,
    output logic [DIM-1:0][DW-1:0] arr_y
);

    // a_q[r][k] = A[r][k] and b_q[c][k] = B[k][c], so both edges use the same skew rule.
    int8_t [DIM-1:0][DIM-1:0] a_q, a_d;
    int8_t [DIM-1:0][DIM-1:0] b_q, b_d;
    int8_t [DIM-1:0]          x_q, x_d;
    int8_t [DIM-1:0]          y_q, y_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (ld_we) begin
            if (ld_sel) begin
                b_d[ld_idx] = ld_data;
            end else begin
                a_d[ld_idx] = ld_data;
            end
        end
    end

    always_comb begin
        x_d = '0;
        y_d = '0;
        if (feed_en) begin
            for (int i = 0; i < int'(DIM); i++) begin
                for (int k = 0; k < int'(DIM); k++) begin
                    if (skew_hit(int'(phase), i, k)) begin
                        x_d[i] = a_q[i][k];
                        y_d[i] = b_q[i][k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            x_q <= '0;
            y_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign arr_x = x_q;
    assign arr_y = y_q;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the 4x4 int8 output-stationary systolic array: load, clear, skewed feed, drain,
// snapshot and row-wise return. Define SYSTOLIC_PERF_CNT_EN to enable the busy-cycle counter.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned DIM       = systolic_pkg::DIM,
    parameter int unsigned DW        = systolic_pkg::DW,
    parameter int unsigned RW        = systolic_pkg::RW,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic                       ld_sel,
    input  logic [1:0]                 ld_idx,
    input  logic [DIM*DW-1:0]          ld_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       arr_rst,
    output logic [DIM-1:0][DW-1:0]     arr_x,
    output logic [DIM-1:0][DW-1:0]     arr_y,
    input  logic [DIM*DIM-1:0][RW-1:0] arr_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [1:0]                 res_row,
    output logic [DIM*RW-1:0]          res_data,
    output logic                       res_last,
    output logic [31:0]                perf_cyc
);

    if (DIM != 4 || DW != systolic_pkg::DW || RW != systolic_pkg::RW || DRAIN_CYC < 1)
    begin : g_param_check
        $error("systolic_seq_ctrl: only DIM=4, DW=8, RW=16, DRAIN_CYC>=1 supported");
    end

    localparam int unsigned CNT_MAX = (DRAIN_CYC > FEED_CYC) ? DRAIN_CYC : FEED_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             row_q, row_d;
    acc16_t [DIM*DIM-1:0]   res_q, res_d;

    logic                   ld_we;
    logic                   feed_en;
    logic [PH_W-1:0]        phase;
    logic                   busy_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        res_d   = res_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StClear;
            end
            StClear: begin
                state_d = StFeed;
                cnt_d   = '0;
            end
            StFeed: begin
                if (cnt_q == CNT_W'(FEED_CYC - 1)) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDrain: begin
                // The array has fully drained by this edge; capture all 16 accumulators at once.
                if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
                    state_d = StOut;
                    cnt_d   = '0;
                    row_d   = '0;
                    res_d   = arr_out;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StOut: begin
                if (res_ready) begin
                    if (row_q == 2'(DIM - 1)) begin
                        state_d = StIdle;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            row_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            res_q   <= res_d;
        end
    end

    // Feed outputs are registered, so the skew mux looks at the upcoming phase.
    assign feed_en = (state_d == StFeed);
    assign phase   = PH_W'(cnt_d);
    assign ld_we   = ld_valid && (state_q == StIdle);

    systolic_skew_feed u_feed (
        .clk     (clk),
        .rst     (rst),
        .ld_we   (ld_we),
        .ld_sel  (ld_sel),
        .ld_idx  (ld_idx),
        .ld_data (ld_data),
        .feed_en (feed_en),
        .phase   (phase),
        .arr_x   (arr_x),
        .arr_y   (arr_y)
    );

    assign busy_w    = (state_q != StIdle);
    assign busy      = busy_w;
    assign ld_ready  = (state_q == StIdle);
    assign arr_rst   = rst || (state_q == StClear);
    assign res_valid = (state_q == StOut);
    assign res_row   = row_q;
    assign res_last  = (state_q == StOut) && (row_q == 2'(DIM - 1));

    always_comb begin
        res_data = '0;
        for (int c = 0; c < int'(DIM); c++) begin
            res_data[c*RW +: RW] = res_q[{row_q, IDX_W'(c)}];
        end
    end

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (busy_w && (perf_q != '1)) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cyc = perf_q;
`else
    assign perf_cyc = '0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: behavioural 4x4 array harness plus a plain
// matrix-product reference (16-bit wrap) for every returned row.
module tb_systolic_seq_ctrl;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic              ld_sel = 1'b0;
    logic [1:0]        ld_idx = '0;
    logic [31:0]       ld_data = '0;
    logic              start = 1'b0;
    logic              busy;
    logic              arr_rst;
    logic [3:0][7:0]   arr_x;
    logic [3:0][7:0]   arr_y;
    logic [15:0][15:0] arr_out;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [1:0]        res_row;
    logic [63:0]       res_data;
    logic              res_last;
    logic [31:0]       perf_cyc;

    int n_chk  = 0;
    int n_pass = 0;
    int a_m [4][4];
    int b_m [4][4];

    always #5 clk = ~clk;

    systolic_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_sel    (ld_sel),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .start     (start),
        .busy      (busy),
        .arr_rst   (arr_rst),
        .arr_x     (arr_x),
        .arr_y     (arr_y),
        .arr_out   (arr_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_row   (res_row),
        .res_data  (res_data),
        .res_last  (res_last),
        .perf_cyc  (perf_cyc)
    );

    // Output-stationary array harness: operands hop one PE per cycle right (x) and down (y).
    logic [7:0]  xr  [4][4];
    logic [7:0]  yr  [4][4];
    logic [15:0] acc [4][4];

    function automatic logic [7:0] xin(input int r, input int c);
        return (c == 0) ? arr_x[r] : xr[r][c-1];
    endfunction

    function automatic logic [7:0] yin(input int r, input int c);
        return (r == 0) ? arr_y[c] : yr[r-1][c];
    endfunction

    function automatic logic [15:0] mul8(input logic signed [7:0] a, input logic signed [7:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    always @(posedge clk) begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (arr_rst) begin
                    acc[r][c] <= '0;
                    xr[r][c]  <= '0;
                    yr[r][c]  <= '0;
                end else begin
                    acc[r][c] <= acc[r][c] + mul8(xin(r, c), yin(r, c));
                    xr[r][c]  <= xin(r, c);
                    yr[r][c]  <= yin(r, c);
                end
            end
        end
    end

    always_comb begin
        arr_out = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) arr_out[r*4+c] = acc[r][c];
        end
    end

    function automatic logic [63:0] exp_row(input int r);
        logic [63:0] e;
        int s;
        e = '0;
        for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += a_m[r][k] * b_m[k][c];
            e[16*c +: 16] = 16'(s);
        end
        return e;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic load_mats();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < 4; k++) d[8*k +: 8] = (s == 0) ? 8'(a_m[i][k]) : 8'(b_m[k][i]);
                ld_valid = 1'b1;
                ld_sel   = s[0];
                ld_idx   = 2'(i);
                ld_data  = d;
                @(negedge clk);
            end
        end
        ld_valid = 1'b0;
    endtask

    task automatic run_job(input string name, input int stall_row, input int stall_len,
                           input int start_poke, input bit ld_poke);
        int          n;
        int          er;
        int          stalls;
        int          guard;
        bit          rdy;
        logic [63:0] e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || arr_rst !== 1'b1 || arr_x !== '0 || arr_y !== '0)
            $display("FAIL %s clear: busy=%b arr_rst=%b x=%h y=%h, want 1 1 0 0",
                     name, busy, arr_rst, arr_x, arr_y);
        else n_pass++;
        n = 1;
        while (res_valid !== 1'b1 && n < 40) begin
            start = (n == start_poke);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        n_chk++;
        if (n != 13) $display("FAIL %s latency: got %0d cycles, want 13", name, n);
        else n_pass++;
        er = 0;
        stalls = 0;
        guard = 0;
        while (er < 4 && guard < 60) begin
            e = exp_row(er);
            n_chk++;
            if (res_valid !== 1'b1 || res_row !== 2'(er) || res_data !== e ||
                res_last !== (er == 3))
                $display("FAIL %s row%0d: valid=%b row=%0d data=%h last=%b, want 1 %0d %h %b",
                         name, er, res_valid, res_row, res_data, res_last, er, e, er == 3);
            else n_pass++;
            ld_valid = ld_poke && (er < 3);
            ld_sel   = 1'($urandom);
            ld_idx   = 2'($urandom);
            ld_data  = $urandom;
            if (ld_poke) begin
                n_chk++;
                if (ld_ready !== 1'b0) $display("FAIL %s ld_ready in OUT: got %b want 0",
                                                name, ld_ready);
                else n_pass++;
            end
            rdy = !(er == stall_row && stalls < stall_len);
            if (!rdy) stalls++;
            res_ready = rdy;
            @(negedge clk);
            if (rdy) er++;
            guard++;
        end
        res_ready = 1'b0;
        ld_valid  = 1'b0;
        n_chk++;
        if (er != 4) $display("FAIL %s rows accepted: got %0d want 4", name, er);
        else n_pass++;
        n_chk++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1)
            $display("FAIL %s idle after: valid=%b busy=%b ld_ready=%b, want 0 0 1",
                     name, res_valid, busy, ld_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (arr_rst !== 1'b1 || ld_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 ||
            res_row !== 2'd0 || res_last !== 1'b0 || perf_cyc !== 32'd0 || arr_x !== '0 ||
            arr_y !== '0 || res_data !== '0)
            $display("FAIL reset: arr_rst=%b ld_ready=%b busy=%b valid=%b row=%0d last=%b perf=%0d x=%h y=%h data=%h, want 1 1 0 0 0 0 0 0 0 0",
                     arr_rst, ld_ready, busy, res_valid, res_row, res_last, perf_cyc,
                     arr_x, arr_y, res_data);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (arr_rst !== 1'b0) $display("FAIL reset release arr_rst: got %b want 0", arr_rst);
        else n_pass++;
    endtask

    task automatic test_identity();
        logic [31:0] perf_exp;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = (r == c) ? 1 : 0;
                b_m[r][c] = r * 4 + c + 1;
            end
        load_mats();
        run_job("identity", -1, 0, -1, 1'b0);
`ifdef SYSTOLIC_PERF_CNT_EN
        perf_exp = 32'd16;
`else
        perf_exp = 32'd0;
`endif
        n_chk++;
        if (perf_cyc !== perf_exp) $display("FAIL perf_cyc: got %0d want %0d", perf_cyc, perf_exp);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = 127;
                b_m[r][c] = -128;
            end
        load_mats();
        run_job("wrap", -1, 0, -1, 1'b0);
    endtask

    task automatic test_stall();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = rnd8();
                b_m[r][c] = rnd8();
            end
        load_mats();
        run_job("stall", 1, 5, -1, 1'b0);
    endtask

    task automatic test_abort();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = rnd8();
                b_m[r][c] = rnd8();
            end
        load_mats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || ld_ready !== 1'b1)
            $display("FAIL abort: busy=%b valid=%b ld_ready=%b, want 0 0 1",
                     busy, res_valid, ld_ready);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = 0;
                b_m[r][c] = 0;
            end
        run_job("zeroed_bufs", -1, 0, -1, 1'b0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = (r == c) ? 1 : 0;
                b_m[r][c] = (r == c) ? 1 : 0;
            end
        load_mats();
        run_job("after_abort", -1, 0, -1, 1'b0);
    endtask

    task automatic test_ignore_and_back_to_back();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = rnd8();
                b_m[r][c] = rnd8();
            end
        load_mats();
        run_job("drain_start", 2, 2, 10, 1'b1);
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL start queued: busy=%b want 0", busy);
        else n_pass++;
        run_job("b2b_first", -1, 0, -1, 1'b0);
        run_job("b2b_second", -1, 0, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    a_m[r][c] = rnd8();
                    b_m[r][c] = rnd8();
                end
            load_mats();
            run_job("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), -1, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = 0;
                b_m[r][c] = 0;
            end
        test_reset();
        test_identity();
        test_wrap();
        test_stall();
        test_abort();
        test_ignore_and_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
